sprite_draw: RTL and testbench
==============================

SPRITE_DRAW -- requirements
Module: sprite_draw

Interface
REQ-001 SHALL have parameter ROW_BYTES, default 16, meaning bytes per framebuffer row (128 pixels, bit-packed).
REQ-002 SHALL have parameter ROWS, default 64, meaning framebuffer rows; ROW_BYTES*ROWS = 1024 vram bytes.
REQ-003 SHALL have port sys_clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port sys_rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle draw request (CHIP-8 DXYN).
REQ-006 SHALL have ports x  input  8, y  input  8, n  input  4, i_addr  input  12: sprite X, Y, row count, sprite base address, sampled when start is accepted.
REQ-007 SHALL have ports mem_addr  output  12 and mem_rdata  input  8: main-RAM read port, data valid one cycle after address.
REQ-008 SHALL have ports vram_addr  output  10 and vram_rdata  input  8: vram read port, data valid one cycle after address.
REQ-009 SHALL have ports vram_we  output  1 and vram_wdata  output  8: vram write, at vram_addr, on the cycle vram_we is high.
REQ-010 SHALL have ports busy  output  1, done  output  1, collision  output  1.

Function
REQ-011 Pixel layout SHALL be: byte address = row*16 + col/8; bit 7 = leftmost pixel.
REQ-012 On accepted start: x0 = x mod 128, y0 = y mod 64, r = 0, collision cleared, busy = 1 next cycle.
REQ-013 start SHALL be ignored while busy = 1.
REQ-014 States SHALL be IDLE, FETCH, RD_L, WR_L, RD_R, WR_R, DONE.
REQ-015 FETCH: mem_addr = i_addr + r (mod 4096).
REQ-016 RD_L: latch sprite byte s = mem_rdata; vram_addr = (y0+r)*16 + x0/8.
REQ-017 WR_L: vram_wdata = vram_rdata ^ (s >> (x0 mod 8)); vram_we = 1; collision |= |(vram_rdata & (s >> (x0 mod 8))).
REQ-018 RD_R/WR_R SHALL run only if x0 mod 8 != 0 and x0/8 < 15; they operate on address+1 using bits shifted out, i.e. (s << (8 - x0 mod 8)) & 0xFF.
REQ-019 After a row, r increments; go to FETCH if r < n and y0+r < 64, else DONE (bottom clip, no vertical wrap).
REQ-020 Pixels past column 127 SHALL be clipped, never wrapped.
REQ-021 n = 0: start -> DONE directly; no memory or vram access.
REQ-022 DONE: done = 1 for exactly one cycle, busy = 0 in that same cycle, then IDLE.
REQ-023 Latency: aligned row = 3 cycles, unaligned unclipped row = 5 cycles; done asserts 3N+1 (aligned) cycles after start.
REQ-024 collision SHALL hold its value from DONE until the next accepted start.
REQ-025 vram_we SHALL be high only in WR_L/WR_R; vram_addr/mem_addr don't-care elsewhere.

Reset
REQ-026 While sys_rst = 1: state IDLE, busy = 0, done = 0, collision = 0, vram_we = 0, r = 0.
REQ-027 Reset mid-draw SHALL abort with no further vram writes from the cycle after sys_rst is sampled high.

Structure
REQ-028 Package chip8_pkg SHALL hold ROW_BYTES, ROWS, VRAM_BYTES and the draw-state enum, shared with the display stage.
REQ-029 One sub-module, sprite_shift (combinational 8-bit sprite + 3-bit offset -> left/right masks), is natural; FSM stays in sprite_draw.

Verification
REQ-030 Aligned: x=8, y=0, n=1, i_addr=0x200, mem[0x200]=0xF0, vram[1]=0x00 -> vram[1]=0xF0, collision=0, done 4 cycles after start.
REQ-031 Unaligned: x=4, y=1, n=1, sprite 0xFF, vram zero -> vram[16]=0x0F, vram[17]=0xF0, done 6 cycles after start.
REQ-032 Collision: repeat REQ-031 draw -> vram[16]=vram[17]=0x00, collision=1 held until next start.
REQ-033 Clip: x=124, y=63, n=2, sprite 0xFF,0xFF -> only vram[1023]^=0x0F; no write to 1024-wrap or row 0; done after one row.
REQ-034 Reset: sys_rst pulsed during WR_L of row 2 of n=4 -> no later vram_we, busy=0, collision=0; start ignored while busy; n=0 -> done next cycle, no accesses.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared framebuffer geometry and draw-state encoding for the CHIP-8 sprite and display stages.
package chip8_pkg;

   localparam int unsigned ROW_BYTES  = 16;
   localparam int unsigned ROWS       = 64;
   localparam int unsigned VRAM_BYTES = ROW_BYTES * ROWS;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StRdL,
      StWrL,
      StRdR,
      StWrR,
      StDone
   } draw_state_e;

endpackage

// File: rtl/sprite_shift.sv
// Splits one sprite byte across two framebuffer bytes for a given pixel offset.
module sprite_shift (
   input  logic [7:0] sprite,
   input  logic [2:0] offset,
   output logic [7:0] left_mask,
   output logic [7:0] right_mask
);

   logic [15:0] spread;

   // Upper byte lands at col, lower byte holds the bits pushed into col+1.
   always_comb begin
      spread     = {sprite, 8'h00} >> offset;
      left_mask  = spread[15:8];
      right_mask = spread[7:0];
   end

endmodule

// File: rtl/sprite_draw.sv
// CHIP-8 DXYN sprite blitter: XORs N sprite rows into a bit-packed vram with clipping
// and a sticky collision flag.
module sprite_draw #(
   parameter int unsigned ROW_BYTES = chip8_pkg::ROW_BYTES,
   parameter int unsigned ROWS      = chip8_pkg::ROWS
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        start,
   input  logic [7:0]  x,
   input  logic [7:0]  y,
   input  logic [3:0]  n,
   input  logic [11:0] i_addr,
   output logic [11:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   output logic [9:0]  vram_addr,
   input  logic [7:0]  vram_rdata,
   output logic        vram_we,
   output logic [7:0]  vram_wdata,
   output logic        busy,
   output logic        done,
   output logic        collision
);

   import chip8_pkg::*;

   localparam int unsigned COL_W = $clog2(ROW_BYTES);
   localparam int unsigned ROW_W = $clog2(ROWS);
   localparam int unsigned X_W   = COL_W + 3;

   draw_state_e    state_q;
   logic [X_W-1:0]   x0_q;
   logic [ROW_W-1:0] y0_q;
   logic [3:0]       n_q;
   logic [3:0]       r_q;
   logic [11:0]      base_q;
   logic [7:0]       spr_q;
   logic             busy_q;
   logic             done_q;
   logic             coll_q;

   logic [2:0]       offset;
   logic [COL_W-1:0] col;
   logic [ROW_W:0]   row_sum;
   logic [ROW_W:0]   next_row;
   logic [4:0]       r_inc;
   logic             need_right;
   logic             last_row;
   logic [7:0]       left_mask;
   logic [7:0]       right_mask;
   logic             unused_bits;

   assign offset      = x0_q[2:0];
   assign col         = x0_q[X_W-1:3];
   assign row_sum     = (ROW_W+1)'(y0_q) + (ROW_W+1)'(r_q);
   assign r_inc       = {1'b0, r_q} + 5'd1;
   assign next_row    = (ROW_W+1)'(y0_q) + (ROW_W+1)'(r_inc);
   // Right byte only exists when the sprite straddles bytes and is not at the last column.
   assign need_right  = (offset != 3'd0) && (col != COL_W'(ROW_BYTES - 1));
   assign last_row    = (r_inc >= {1'b0, n_q}) || (next_row >= (ROW_W+1)'(ROWS));
   assign unused_bits = ^{x[7:X_W], y[7:ROW_W], row_sum[ROW_W]};

   sprite_shift u_shift (
      .sprite     (spr_q),
      .offset     (offset),
      .left_mask  (left_mask),
      .right_mask (right_mask)
   );

   always_comb begin
      mem_addr   = base_q + 12'(r_q);
      vram_addr  = 10'({row_sum[ROW_W-1:0], col});
      vram_wdata = vram_rdata ^ left_mask;
      if (state_q == StRdR || state_q == StWrR) begin
         vram_addr  = 10'({row_sum[ROW_W-1:0], col + COL_W'(1)});
         vram_wdata = vram_rdata ^ right_mask;
      end
      // Gated by reset so an abort suppresses the write already in flight.
      vram_we = ~sys_rst & ((state_q == StWrL) || (state_q == StWrR));
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign collision = coll_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         coll_q  <= 1'b0;
         r_q     <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  x0_q   <= x[X_W-1:0];
                  y0_q   <= y[ROW_W-1:0];
                  n_q    <= n;
                  base_q <= i_addr;
                  r_q    <= '0;
                  coll_q <= 1'b0;
                  if (n == 4'd0) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StFetch;
                     busy_q  <= 1'b1;
                  end
               end
            end
            StFetch: state_q <= StRdL;
            StRdL: begin
               spr_q   <= mem_rdata;
               state_q <= StWrL;
            end
            StWrL: begin
               coll_q <= coll_q | (|(vram_rdata & left_mask));
               if (need_right) begin
                  state_q <= StRdR;
               end else begin
                  r_q <= r_inc[3:0];
                  if (last_row) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= StFetch;
                  end
               end
            end
            StRdR: state_q <= StWrR;
            StWrR: begin
               coll_q <= coll_q | (|(vram_rdata & right_mask));
               r_q    <= r_inc[3:0];
               if (last_row) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= StFetch;
               end
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw with synchronous-read RAM and vram models.
module tb_sprite_draw;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        start;
   logic [7:0]  x;
   logic [7:0]  y;
   logic [3:0]  n;
   logic [11:0] i_addr;
   logic [11:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic [9:0]  vram_addr;
   logic [7:0]  vram_rdata;
   logic        vram_we;
   logic [7:0]  vram_wdata;
   logic        busy;
   logic        done;
   logic        collision;

   logic [7:0] mem  [4096];
   logic [7:0] vram [1024];
   int checks   = 0;
   int failures = 0;
   int wr_count = 0;

   sprite_draw dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .start      (start),
      .x          (x),
      .y          (y),
      .n          (n),
      .i_addr     (i_addr),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .vram_addr  (vram_addr),
      .vram_rdata (vram_rdata),
      .vram_we    (vram_we),
      .vram_wdata (vram_wdata),
      .busy       (busy),
      .done       (done),
      .collision  (collision)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      mem_rdata  <= mem[mem_addr];
      vram_rdata <= vram[vram_addr];
      if (vram_we) begin
         vram[vram_addr] <= vram_wdata;
         wr_count        <= wr_count + 1;
      end
   end

   // Returns latency in cycles after the start cycle (-1 on timeout), plus status snapshots.
   task automatic do_draw(input logic [7:0] xx, input logic [7:0] yy, input logic [3:0] nn,
                          input logic [11:0] ia, output int lat, output logic busy_at_done,
                          output logic coll_after_start, output logic done_next);
      @(negedge sys_clk);
      x = xx; y = yy; n = nn; i_addr = ia; start = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      lat = 1;
      coll_after_start = collision;
      while (!done && lat < 40) begin
         @(posedge sys_clk); #1;
         lat++;
      end
      if (!done) lat = -1;
      busy_at_done = busy;
      @(posedge sys_clk); #1;
      done_next = done;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1; start = 1'b0;
      x = '0; y = '0; n = '0; i_addr = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (collision !== 1'b0) begin failures++; $display("FAIL reset_coll got=%b exp=0", collision); end
      checks++; if (vram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", vram_we); end
      sys_rst = 1'b0;
      @(posedge sys_clk); #1;
   endtask

   task automatic test_aligned();
      int lat; logic bd, cs, dn; int base;
      mem[12'h200] = 8'hF0;
      vram[1] = 8'h00;
      base = wr_count;
      do_draw(8'd8, 8'd0, 4'd1, 12'h200, lat, bd, cs, dn);
      checks++; if (lat !== 4) begin failures++; $display("FAIL aligned_latency got=%0d exp=4", lat); end
      checks++; if (bd !== 1'b0) begin failures++; $display("FAIL aligned_busy_at_done got=%b exp=0", bd); end
      checks++; if (dn !== 1'b0) begin failures++; $display("FAIL aligned_done_width got=%b exp=0", dn); end
      checks++; if (vram[1] !== 8'hF0) begin failures++; $display("FAIL aligned_vram1 got=%h exp=f0", vram[1]); end
      checks++; if (collision !== 1'b0) begin failures++; $display("FAIL aligned_coll got=%b exp=0", collision); end
      checks++; if (wr_count - base !== 1) begin failures++; $display("FAIL aligned_writes got=%0d exp=1", wr_count - base); end
   endtask

   task automatic test_unaligned();
      int lat; logic bd, cs, dn; int base;
      mem[12'h300] = 8'hFF;
      base = wr_count;
      do_draw(8'd4, 8'd1, 4'd1, 12'h300, lat, bd, cs, dn);
      checks++; if (lat !== 6) begin failures++; $display("FAIL unaligned_latency got=%0d exp=6", lat); end
      checks++; if (vram[16] !== 8'h0F) begin failures++; $display("FAIL unaligned_vram16 got=%h exp=0f", vram[16]); end
      checks++; if (vram[17] !== 8'hF0) begin failures++; $display("FAIL unaligned_vram17 got=%h exp=f0", vram[17]); end
      checks++; if (collision !== 1'b0) begin failures++; $display("FAIL unaligned_coll got=%b exp=0", collision); end
      checks++; if (wr_count - base !== 2) begin failures++; $display("FAIL unaligned_writes got=%0d exp=2", wr_count - base); end
   endtask

   task automatic test_collision();
      int lat; logic bd, cs, dn;
      do_draw(8'd4, 8'd1, 4'd1, 12'h300, lat, bd, cs, dn);
      checks++; if (lat !== 6) begin failures++; $display("FAIL coll_latency got=%0d exp=6", lat); end
      checks++; if (vram[16] !== 8'h00) begin failures++; $display("FAIL coll_vram16 got=%h exp=00", vram[16]); end
      checks++; if (vram[17] !== 8'h00) begin failures++; $display("FAIL coll_vram17 got=%h exp=00", vram[17]); end
      checks++; if (collision !== 1'b1) begin failures++; $display("FAIL coll_flag got=%b exp=1", collision); end
      repeat (5) @(posedge sys_clk);
      #1;
      checks++; if (collision !== 1'b1) begin failures++; $display("FAIL coll_hold got=%b exp=1", collision); end
   endtask

   task automatic test_clip();
      int lat; logic bd, cs, dn; int base;
      mem[12'h400] = 8'hFF;
      mem[12'h401] = 8'hFF;
      vram[0]    = 8'hAA;
      vram[1008] = 8'h55;
      vram[1023] = 8'h00;
      base = wr_count;
      do_draw(8'd124, 8'd63, 4'd2, 12'h400, lat, bd, cs, dn);
      checks++; if (cs !== 1'b0) begin failures++; $display("FAIL clip_coll_cleared got=%b exp=0", cs); end
      checks++; if (lat !== 4) begin failures++; $display("FAIL clip_latency got=%0d exp=4", lat); end
      checks++; if (vram[1023] !== 8'h0F) begin failures++; $display("FAIL clip_vram1023 got=%h exp=0f", vram[1023]); end
      checks++; if (vram[0] !== 8'hAA) begin failures++; $display("FAIL clip_vram0 got=%h exp=aa", vram[0]); end
      checks++; if (vram[1008] !== 8'h55) begin failures++; $display("FAIL clip_vram1008 got=%h exp=55", vram[1008]); end
      checks++; if (wr_count - base !== 1) begin failures++; $display("FAIL clip_writes got=%0d exp=1", wr_count - base); end
   endtask

   task automatic test_multirow();
      int lat; logic bd, cs, dn;
      mem[12'h600] = 8'h3C;
      mem[12'h601] = 8'hC3;
      do_draw(8'd16, 8'd2, 4'd2, 12'h600, lat, bd, cs, dn);
      checks++; if (lat !== 7) begin failures++; $display("FAIL multirow_latency got=%0d exp=7", lat); end
      checks++; if (vram[34] !== 8'h3C) begin failures++; $display("FAIL multirow_vram34 got=%h exp=3c", vram[34]); end
      checks++; if (vram[50] !== 8'hC3) begin failures++; $display("FAIL multirow_vram50 got=%h exp=c3", vram[50]); end
   endtask

   task automatic test_zero_n();
      int lat; logic bd, cs, dn; int base;
      base = wr_count;
      do_draw(8'd0, 8'd0, 4'd0, 12'h700, lat, bd, cs, dn);
      checks++; if (lat !== 1) begin failures++; $display("FAIL zero_n_latency got=%0d exp=1", lat); end
      checks++; if (bd !== 1'b0) begin failures++; $display("FAIL zero_n_busy got=%b exp=0", bd); end
      checks++; if (dn !== 1'b0) begin failures++; $display("FAIL zero_n_done_width got=%b exp=0", dn); end
      checks++; if (wr_count - base !== 0) begin failures++; $display("FAIL zero_n_writes got=%0d exp=0", wr_count - base); end
   endtask

   task automatic test_reset_mid_draw();
      int cyc; int base;
      mem[12'h500] = 8'h81;
      mem[12'h501] = 8'h42;
      mem[12'h502] = 8'h24;
      mem[12'h503] = 8'h18;
      vram[160] = 8'h01;
      @(negedge sys_clk);
      x = 8'd0; y = 8'd10; n = 4'd4; i_addr = 12'h500; start = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      base = wr_count;
      cyc = 1;
      while (cyc < 9) begin
         @(posedge sys_clk); #1;
         cyc++;
         if (cyc == 2) begin
            x = 8'd64; n = 4'd1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      checks++; if (vram_we !== 1'b1) begin failures++; $display("FAIL mid_row2_we got=%b exp=1", vram_we); end
      checks++; if (collision !== 1'b1) begin failures++; $display("FAIL mid_coll_before got=%b exp=1", collision); end
      sys_rst = 1'b1;
      #1;
      checks++; if (vram_we !== 1'b0) begin failures++; $display("FAIL mid_we_in_reset got=%b exp=0", vram_we); end
      @(posedge sys_clk); #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
      checks++; if (collision !== 1'b0) begin failures++; $display("FAIL mid_coll got=%b exp=0", collision); end
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      repeat (10) @(posedge sys_clk);
      #1;
      checks++; if (wr_count - base !== 2) begin failures++; $display("FAIL mid_writes got=%0d exp=2", wr_count - base); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_after got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_done_after got=%b exp=0", done); end
      checks++; if (vram[160] !== 8'h80) begin failures++; $display("FAIL mid_vram160 got=%h exp=80", vram[160]); end
      checks++; if (vram[176] !== 8'h42) begin failures++; $display("FAIL mid_vram176 got=%h exp=42", vram[176]); end
      checks++; if (vram[168] !== 8'h00) begin failures++; $display("FAIL mid_ignored_start got=%h exp=00", vram[168]); end
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
      for (int a = 0; a < 1024; a++) vram[a] = 8'h00;
      test_reset();
      test_aligned();
      test_unaligned();
      test_collision();
      test_clip();
      test_multirow();
      test_zero_n();
      test_reset_mid_draw();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
